// File: rtl/grn_node_lut.sv
// GRN node: truth-table next-state function with divided s0 phase,
// undivided s1 phase, change pulse and saturating toggle counter.
module grn_node_lut #(
   parameter int NUM_IN = 4,
   parameter int DIV_W  = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reset_nos,
   input  logic              start_s0,
   input  logic              start_s1,
   input  logic              init_state,
   input  logic [NUM_IN-1:0] in_s0,
   input  logic [NUM_IN-1:0] in_s1,
   input  logic [DIV_W-1:0]  div,
   input  logic              cfg_we,
   input  logic [NUM_IN-1:0] cfg_addr,
   input  logic              cfg_data,
   output logic              s0,
   output logic              s1,
   output logic              node_s0,
   output logic              node_s1,
   output logic              changed_s0,
   output logic [CNT_W-1:0]  toggle_cnt
);

   localparam int DEPTH = 2 ** NUM_IN;

   logic [DEPTH-1:0] lut_q, lut_d;
   logic             s0_q, s0_d;
   logic             s1_q, s1_d;
   logic             chg_q, chg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] dcnt_q, dcnt_d;
   logic             ev0;
   logic             ev1;

   // Both phases read the pre-write LUT contents this cycle
   assign ev0 = lut_q[in_s0];
   assign ev1 = lut_q[in_s1];

   always_comb begin
      lut_d  = lut_q;
      s0_d   = s0_q;
      s1_d   = s1_q;
      chg_d  = 1'b0;
      cnt_d  = cnt_q;
      dcnt_d = dcnt_q;
      if (cfg_we) begin
         lut_d[cfg_addr] = cfg_data;
      end
      if (reset_nos) begin
         s0_d   = init_state;
         s1_d   = init_state;
         cnt_d  = '0;
         dcnt_d = '0;
      end else begin
         if (start_s0) begin
            if (dcnt_q == '0) begin
               s0_d   = ev0;
               dcnt_d = div;
               if (ev0 != s0_q) begin
                  chg_d = 1'b1;
                  if (cnt_q != '1) begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end else begin
               dcnt_d = dcnt_q - DIV_W'(1);
            end
         end
         if (start_s1) begin
            s1_d = ev1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lut_q  <= '0;
         s0_q   <= 1'b0;
         s1_q   <= 1'b0;
         chg_q  <= 1'b0;
         cnt_q  <= '0;
         dcnt_q <= '0;
      end else begin
         lut_q  <= lut_d;
         s0_q   <= s0_d;
         s1_q   <= s1_d;
         chg_q  <= chg_d;
         cnt_q  <= cnt_d;
         dcnt_q <= dcnt_d;
      end
   end

   assign s0         = s0_q;
   assign s1         = s1_q;
   assign node_s0    = s0_q;
   assign node_s1    = s1_q;
   assign changed_s0 = chg_q;
   assign toggle_cnt = cnt_q;

endmodule

// File: tb/tb_grn_node_lut.sv
// Scoreboard bench for grn_node_lut: a default instance plus a
// CNT_W=2 instance sharing stimulus to exercise counter saturation.
module tb_grn_node_lut;

   localparam int AW = 28;

   logic       clk;
   logic       rst;
   logic       reset_nos;
   logic       start_s0;
   logic       start_s1;
   logic       init_state;
   logic [3:0] in_s0;
   logic [3:0] in_s1;
   logic [3:0] div;
   logic       cfg_we;
   logic [3:0] cfg_addr;
   logic       cfg_data;

   logic        s0, s1, node_s0, node_s1, changed_s0;
   logic [15:0] toggle_cnt;
   logic        s0b, s1b, ns0b, ns1b, chgb;
   logic [1:0]  cntb;

   logic        m_s0, m_s1, m_chg;
   logic [15:0] m_cnt;
   logic [1:0]  m_cnt2;
   logic [3:0]  m_dcnt;
   logic [15:0] m_lut;

   logic [AW-1:0] exp_q[$];
   logic [AW-1:0] act_q[$];
   logic [AW-1:0] e, a;

   int total = 0;
   int bad   = 0;

   grn_node_lut u_dut (
      .clk(clk), .rst(rst), .reset_nos(reset_nos),
      .start_s0(start_s0), .start_s1(start_s1),
      .init_state(init_state), .in_s0(in_s0), .in_s1(in_s1),
      .div(div), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .s0(s0), .s1(s1),
      .node_s0(node_s0), .node_s1(node_s1),
      .changed_s0(changed_s0), .toggle_cnt(toggle_cnt)
   );

   grn_node_lut #(.CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .reset_nos(reset_nos),
      .start_s0(start_s0), .start_s1(start_s1),
      .init_state(init_state), .in_s0(in_s0), .in_s1(in_s1),
      .div(div), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .s0(s0b), .s1(s1b),
      .node_s0(ns0b), .node_s1(ns1b),
      .changed_s0(chgb), .toggle_cnt(cntb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [AW-1:0] actual();
      return {s0, s1, node_s0, node_s1, changed_s0, toggle_cnt,
              s0b, s1b, ns0b, ns1b, chgb, cntb};
   endfunction

   task automatic model_reset();
      m_s0 = 1'b0; m_s1 = 1'b0; m_chg = 1'b0;
      m_cnt = '0; m_cnt2 = '0; m_dcnt = '0; m_lut = '0;
   endtask

   // Drive one clock of stimulus, advance the model, queue both sides
   task automatic cyc(input int rn, input int ini, input int a0,
                      input int a1, input int i0, input int i1,
                      input int we, input int wa, input int wd);
      logic [3:0] x0, x1, xa;
      logic n;
      x0 = 4'(i0); x1 = 4'(i1); xa = 4'(wa);
      reset_nos = rn[0]; init_state = ini[0];
      start_s0 = a0[0]; start_s1 = a1[0];
      in_s0 = x0; in_s1 = x1;
      cfg_we = we[0]; cfg_addr = xa; cfg_data = wd[0];
      m_chg = 1'b0;
      if (rn[0]) begin
         m_s0 = ini[0]; m_s1 = ini[0];
         m_cnt = '0; m_cnt2 = '0; m_dcnt = '0;
      end else begin
         if (a0[0]) begin
            if (m_dcnt == 4'd0) begin
               n = m_lut[x0];
               if (n != m_s0) begin
                  m_chg = 1'b1;
                  if (m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
                  if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
               end
               m_s0 = n;
               m_dcnt = div;
            end else begin
               m_dcnt = m_dcnt - 4'd1;
            end
         end
         if (a1[0]) m_s1 = m_lut[x1];
      end
      if (we[0]) m_lut[xa] = wd[0];
      exp_q.push_back({m_s0, m_s1, m_s0, m_s1, m_chg, m_cnt,
                       m_s0, m_s1, m_s0, m_s1, m_chg, m_cnt2});
      @(posedge clk);
      #1;
      act_q.push_back(actual());
   endtask

   task automatic test_reset();
      rst = 1'b0; reset_nos = 0; start_s0 = 0; start_s1 = 0;
      init_state = 0; in_s0 = 0; in_s1 = 0; div = 0;
      cfg_we = 0; cfg_addr = 0; cfg_data = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (actual() !== '0) begin
         bad++;
         $display("FAIL reset_init: got %h want 0", actual());
      end
      rst = 1'b1;
      cyc(0, 0, 0, 0, 0, 0, 1, 1, 1);
      for (int k = 0; k < 5; k++) cyc(0, 0, 1, 0, (k + 1) % 2, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); a = act_q.pop_front();
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL reset_pre: got %h want %h", a, e);
         end
      end
      total++;
      if (s0 !== 1'b1 || toggle_cnt !== 16'd5) begin
         bad++;
         $display("FAIL reset_setup: got s0=%b cnt=%0d want s0=1 cnt=5",
                  s0, toggle_cnt);
      end
      #2 rst = 1'b0;
      #1;
      model_reset();
      total++;
      if (actual() !== '0) begin
         bad++;
         $display("FAIL reset_async: got %h want 0", actual());
      end
      #3 rst = 1'b1;
      cyc(0, 0, 1, 1, 1, 1, 0, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); a = act_q.pop_front();
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL reset_lut: got %h want %h", a, e);
         end
      end
   endtask

   task automatic test_and();
      div = 0;
      for (int k = 0; k < 16; k++) cyc(0, 0, 0, 0, 0, 0, 1, k, k == 3);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 3, 0, 0, 0, 0);
      total++;
      if (s0 !== 1'b1 || changed_s0 !== 1'b1) begin
         bad++;
         $display("FAIL and_hit: got s0=%b chg=%b want 1 1", s0, changed_s0);
      end
      cyc(0, 0, 1, 0, 1, 0, 0, 0, 0);
      total++;
      if (s0 !== 1'b0 || toggle_cnt !== 16'd2) begin
         bad++;
         $display("FAIL and_miss: got s0=%b cnt=%0d want 0 2", s0, toggle_cnt);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); a = act_q.pop_front();
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL and: got %h want %h", a, e);
         end
      end
   endtask

   task automatic test_divider();
      int np;
      logic [5:0] sv;
      div = 4'd2;
      for (int k = 0; k < 16; k++) cyc(0, 0, 0, 0, 0, 0, 1, k, 1);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      np = 0;
      sv = '0;
      for (int k = 0; k < 6; k++) begin
         cyc(0, 0, 1, 0, $urandom_range(0, 15), 0, 0, 0, 0);
         np += int'(changed_s0);
         sv[k] = s0;
      end
      total++;
      if (np !== 1 || sv !== 6'b111111) begin
         bad++;
         $display("FAIL div_pulses: got chg=%0d s0=%b want 1 111111", np, sv);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); a = act_q.pop_front();
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL divider: got %h want %h", a, e);
         end
      end
   endtask

   task automatic test_phase();
      div = 0;
      cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 1, 15, 0);
      cyc(1, 1, 0, 0, 0, 0, 1, 1, 0);
      cyc(0, 0, 1, 1, 0, 15, 0, 0, 0);
      total++;
      if (s0 !== 1'b1 || s1 !== 1'b0) begin
         bad++;
         $display("FAIL phase: got s0=%b s1=%b want 1 0", s0, s1);
      end
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 1, 0, 15, 0, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); a = act_q.pop_front();
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL phase_sb: got %h want %h", a, e);
         end
      end
   endtask

   task automatic test_collision();
      cyc(0, 0, 0, 0, 0, 0, 1, 7, 0);
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 7, 1, 7, 1);
      total++;
      if (s1 !== 1'b0) begin
         bad++;
         $display("FAIL coll_old: got s1=%b want 0", s1);
      end
      cyc(0, 0, 0, 1, 0, 7, 0, 0, 0);
      total++;
      if (s1 !== 1'b1) begin
         bad++;
         $display("FAIL coll_new: got s1=%b want 1", s1);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); a = act_q.pop_front();
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL collision: got %h want %h", a, e);
         end
      end
   endtask

   task automatic test_saturation();
      div = 0;
      cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 1, 1);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) cyc(0, 0, 1, 0, (k + 1) % 2, 0, 0, 0, 0);
      total++;
      if (cntb !== 2'd3 || toggle_cnt !== 16'd5) begin
         bad++;
         $display("FAIL sat: got cnt2=%0d cnt=%0d want 3 5", cntb, toggle_cnt);
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 1, 0, 0, 0, 0, 0, 0);
      total++;
      if (s0 !== 1'b1 || toggle_cnt !== 16'd0 || changed_s0 !== 1'b0 ||
          cntb !== 2'd0) begin
         bad++;
         $display("FAIL prio: got s0=%b cnt=%0d chg=%b want 1 0 0",
                  s0, toggle_cnt, changed_s0);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); a = act_q.pop_front();
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL saturation: got %h want %h", a, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 80; k++) begin
         div = 4'($urandom_range(0, 3));
         cyc($urandom_range(0, 15) == 0, $urandom_range(0, 1),
             $urandom_range(0, 3) != 0, $urandom_range(0, 1),
             $urandom_range(0, 15), $urandom_range(0, 15),
             $urandom_range(0, 2) == 0, $urandom_range(0, 15),
             $urandom_range(0, 1));
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); a = act_q.pop_front();
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL b2b: got %h want %h", a, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_and();
      test_divider();
      test_phase();
      test_collision();
      test_saturation();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
